sc_scratchpad_regbank: RTL and testbench
========================================

Name: sc_scratchpad_regbank

Overview:
- 14-entry x 32-bit scratchpad register bank; the write target of the load-select/decoder stage.
- Consumes that stage's data bus, its active-low one-hot load vector and its active-low clear vector.
- Serves two registered read ports (A, B) to the ALU operand path, addressed by MIR fields.
- Decoder address 2..15 maps to bank entry 0..13 (load/clear bit i = entry i).

Parameters:
- DATAWIDTH_BUS, 32, data word width.
- DATAWIDTH_DECODER_OUT, 14, number of entries; also load/clear vector width.
- DATAWIDTH_MIR_SELECTION, 6, read address width.

Ports:
- SC_REGBANK_CLOCK_50  input  1  system clock; all state on rising edge.
- SC_REGBANK_RESET_InHigh  input  1  synchronous reset, active-high.
- SC_REGBANK_data_InBus  input  DATAWIDTH_BUS  write data from load mux.
- SC_REGBANK_Load_InLow  input  DATAWIDTH_DECODER_OUT  per-entry write enable, active-low.
- SC_REGBANK_Clear_InLow  input  DATAWIDTH_DECODER_OUT  per-entry clear, active-low.
- SC_REGBANK_AddrA_InBus  input  DATAWIDTH_MIR_SELECTION  read address, port A.
- SC_REGBANK_AddrB_InBus  input  DATAWIDTH_MIR_SELECTION  read address, port B.
- SC_REGBANK_DataA_OutBus  output  DATAWIDTH_BUS  registered read data, port A.
- SC_REGBANK_DataB_OutBus  output  DATAWIDTH_BUS  registered read data, port B.
- SC_REGBANK_MultiLoad_OutHigh  output  1  sticky error: more than one load bit low in one cycle.
- SC_REGBANK_WriteCount_OutBus  output  8  count of cycles with at least one committed write; saturates at 255.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - Reset cycle forces all 14 entries, DataA, DataB, MultiLoad and WriteCount to 0.
  - Reset overrides load, clear and read activity in the same cycle.
- Write, per entry i at each rising edge (reset low):
  - Clear[i]==0: entry i <= 0. Clear has priority over load.
  - Else Load[i]==0: entry i <= data_InBus.
  - Else: entry i holds its value.
- Multiple low load bits: every selected entry is written. This is legal but flagged by MultiLoad.
- The all-ones load vector is the idle code; no write occurs.
- Read address map, both ports (6-bit address):
  - 2..15 -> entry (addr-2).
  - 0, 1 and 16..63 -> constant 0.
- Read latency: 1 cycle. Address presented in cycle N yields data valid after edge N+1.
- Write-through forwarding: if a port addresses entry i in the cycle entry i is written or cleared, DataX registers the new value (data_InBus or 0), not the old one.
- Ports A and B are independent and may address the same entry; both then show identical data.
- MultiLoad: set on an edge where the popcount of ~Load_InLow is >= 2. Holds at 1 until reset.
  - Load bits whose entries are also being cleared still count.
- WriteCount: increments by 1 on an edge where any load bit is low and that entry's clear bit is high. Clear-only cycles do not count. Holds at 255.
- No combinational path from any input to any output.

Test Plan:
- Reset: preload entries with nonzero data, assert reset 1 cycle -> DataA=DataB=0, MultiLoad=0, WriteCount=0; reading any address returns 0 afterwards.
- Single write/read: Load=14'b11111111111110, data=32'hDEADBEEF, next cycle AddrA=6'd2 -> DataA=32'hDEADBEEF one cycle later; WriteCount=1, MultiLoad=0.
- Forwarding: AddrB=6'd15 while Load=14'b01111111111111, data=32'h12345678 in the same cycle -> DataB=32'h12345678 after that edge, not the old value.
- Clear priority: entry 5 (addr 7) holds 32'hFFFF0000; drive Load[5]=0 and Clear[5]=0 with data=32'hAAAAAAAA -> entry reads 0; WriteCount unchanged.
- Multi-load and out-of-range: Load=14'b11111111111100, data=32'h5 -> addr 2 and addr 3 both read 5, MultiLoad=1 and stays 1. AddrA=6'd0 and AddrA=6'd40 -> DataA=0.
- Saturation: 300 consecutive single-load cycles -> WriteCount=255 and holds; then a reset mid-sequence -> WriteCount=0 on the next edge.

Source files
------------

// File: rtl/sc_scratchpad_regbank.sv
// 14 x 32-bit scratchpad bank with active-low load/clear vectors and two registered read ports.
// Read latency 1 cycle with write-through forwarding; no backpressure, and every cycle is accepted.
module sc_scratchpad_regbank #(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int DATAWIDTH_DECODER_OUT   = 14,
  parameter int DATAWIDTH_MIR_SELECTION = 6
) (
  input  logic                               SC_REGBANK_CLOCK_50,
  input  logic                               SC_REGBANK_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]           SC_REGBANK_data_InBus,
  input  logic [DATAWIDTH_DECODER_OUT-1:0]   SC_REGBANK_Load_InLow,
  input  logic [DATAWIDTH_DECODER_OUT-1:0]   SC_REGBANK_Clear_InLow,
  input  logic [DATAWIDTH_MIR_SELECTION-1:0] SC_REGBANK_AddrA_InBus,
  input  logic [DATAWIDTH_MIR_SELECTION-1:0] SC_REGBANK_AddrB_InBus,
  output logic [DATAWIDTH_BUS-1:0]           SC_REGBANK_DataA_OutBus,
  output logic [DATAWIDTH_BUS-1:0]           SC_REGBANK_DataB_OutBus,
  output logic                               SC_REGBANK_MultiLoad_OutHigh,
  output logic [7:0]                         SC_REGBANK_WriteCount_OutBus
);

  localparam int N = DATAWIDTH_DECODER_OUT;
  localparam int W = DATAWIDTH_BUS;
  localparam int A = DATAWIDTH_MIR_SELECTION;

  logic [W-1:0] bank_q [N];
  logic [W-1:0] bank_d [N];
  logic [W-1:0] data_a_q, data_a_d;
  logic [W-1:0] data_b_q, data_b_d;
  logic         multi_q, multi_d;
  logic [7:0]   count_q, count_d;

  logic [N-1:0] load_act;
  logic [N-1:0] commit_act;

  assign load_act   = ~SC_REGBANK_Load_InLow;
  assign commit_act = load_act & SC_REGBANK_Clear_InLow;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bank_d[i] = bank_q[i];
      if (!SC_REGBANK_Clear_InLow[i]) begin
        bank_d[i] = '0;
      end else if (!SC_REGBANK_Load_InLow[i]) begin
        bank_d[i] = SC_REGBANK_data_InBus;
      end
    end
  end

  // Reads look at the next-state bank so a same-cycle write or clear is forwarded.
  always_comb begin
    data_a_d = '0;
    data_b_d = '0;
    for (int i = 0; i < N; i++) begin
      if (SC_REGBANK_AddrA_InBus == A'(i + 2)) data_a_d = bank_d[i];
      if (SC_REGBANK_AddrB_InBus == A'(i + 2)) data_b_d = bank_d[i];
    end
  end

  // Two or more active load bits leave a nonzero value after clearing the lowest one.
  always_comb begin
    multi_d = multi_q | ((load_act & (load_act - N'(1))) != '0);
    count_d = count_q;
    if ((commit_act != '0) && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge SC_REGBANK_CLOCK_50) begin
    if (SC_REGBANK_RESET_InHigh) begin
      for (int i = 0; i < N; i++) bank_q[i] <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      multi_q  <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      for (int i = 0; i < N; i++) bank_q[i] <= bank_d[i];
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      multi_q  <= multi_d;
      count_q  <= count_d;
    end
  end

  assign SC_REGBANK_DataA_OutBus      = data_a_q;
  assign SC_REGBANK_DataB_OutBus      = data_b_q;
  assign SC_REGBANK_MultiLoad_OutHigh = multi_q;
  assign SC_REGBANK_WriteCount_OutBus = count_q;

endmodule

// File: tb/tb_sc_scratchpad_regbank.sv
// Directed and randomized bench for sc_scratchpad_regbank against an array-based reference model.
module tb_sc_scratchpad_regbank;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [13:0] load_n;
  logic [13:0] clear_n;
  logic [5:0]  addr_a;
  logic [5:0]  addr_b;
  logic [31:0] dout_a;
  logic [31:0] dout_b;
  logic        multi;
  logic [7:0]  wcount;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] m [14];
  logic [31:0] exp_a, exp_b;
  logic        exp_ml;
  int          exp_cnt;

  always #5 clk = ~clk;

  sc_scratchpad_regbank dut (
    .SC_REGBANK_CLOCK_50          (clk),
    .SC_REGBANK_RESET_InHigh      (rst),
    .SC_REGBANK_data_InBus        (data),
    .SC_REGBANK_Load_InLow        (load_n),
    .SC_REGBANK_Clear_InLow       (clear_n),
    .SC_REGBANK_AddrA_InBus       (addr_a),
    .SC_REGBANK_AddrB_InBus       (addr_b),
    .SC_REGBANK_DataA_OutBus      (dout_a),
    .SC_REGBANK_DataB_OutBus      (dout_b),
    .SC_REGBANK_MultiLoad_OutHigh (multi),
    .SC_REGBANK_WriteCount_OutBus (wcount)
  );

  function automatic logic [31:0] ref_read(input logic [5:0] a);
    if (a >= 6'd2 && a <= 6'd15) return m[a - 6'd2];
    return 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Applies one cycle of inputs, advances the model by the bank's rules, then checks all outputs.
  task automatic step(input logic r, input logic [31:0] d, input logic [13:0] ld,
                      input logic [13:0] cl, input logic [5:0] aa, input logic [5:0] ab);
    int nlow;
    bit wrote;
    rst = r; data = d; load_n = ld; clear_n = cl; addr_a = aa; addr_b = ab;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 14; i++) m[i] = 32'd0;
      exp_ml = 1'b0;
      exp_cnt = 0;
      exp_a = 32'd0;
      exp_b = 32'd0;
    end else begin
      nlow = 0;
      wrote = 1'b0;
      for (int i = 0; i < 14; i++) begin
        if (!ld[i]) nlow++;
        if (!cl[i]) m[i] = 32'd0;
        else if (!ld[i]) begin
          m[i] = d;
          wrote = 1'b1;
        end
      end
      if (nlow >= 2) exp_ml = 1'b1;
      if (wrote && exp_cnt < 255) exp_cnt++;
      exp_a = ref_read(aa);
      exp_b = ref_read(ab);
    end
    #1;
    chk("data_a", dout_a, exp_a);
    chk("data_b", dout_b, exp_b);
    chk("multiload", {31'd0, multi}, {31'd0, exp_ml});
    chk("writecount", {24'd0, wcount}, 32'(exp_cnt));
  endtask

  localparam logic [13:0] IDLE = 14'h3FFF;

  initial begin
    logic [13:0] ld, cl;
    logic [5:0]  aa, ab;
    int          saved;
    for (int i = 0; i < 14; i++) m[i] = 32'd0;
    exp_ml = 1'b0; exp_cnt = 0; exp_a = 32'd0; exp_b = 32'd0;
    rst = 1'b1; data = 32'd0; load_n = IDLE; clear_n = IDLE; addr_a = 6'd0; addr_b = 6'd0;
    step(1'b1, 32'd0, IDLE, IDLE, 6'd0, 6'd0);

    // Preload, then reset must wipe everything.
    for (int i = 0; i < 14; i++) step(1'b0, 32'hA5A50000 + 32'(i), ~(14'd1 << i), IDLE, 6'(i + 2), 6'd15);
    step(1'b1, 32'hFFFFFFFF, 14'd0, IDLE, 6'd2, 6'd3);
    chk("rst_data_a", dout_a, 32'd0);
    chk("rst_multi", {31'd0, multi}, 32'd0);
    chk("rst_count", {24'd0, wcount}, 32'd0);
    step(1'b0, 32'd0, IDLE, IDLE, 6'd2, 6'd15);
    chk("rst_read_a", dout_a, 32'd0);
    chk("rst_read_b", dout_b, 32'd0);

    // Single write, read back the next cycle.
    step(1'b0, 32'hDEADBEEF, 14'b11111111111110, IDLE, 6'd0, 6'd0);
    step(1'b0, 32'd0, IDLE, IDLE, 6'd2, 6'd0);
    chk("single_read", dout_a, 32'hDEADBEEF);
    chk("single_count", {24'd0, wcount}, 32'd1);
    chk("single_multi", {31'd0, multi}, 32'd0);

    // Write-through forwarding on port B.
    step(1'b0, 32'h12345678, 14'b01111111111111, IDLE, 6'd0, 6'd15);
    chk("forward_b", dout_b, 32'h12345678);

    // Clear beats load, and a cleared load does not count as a write.
    step(1'b0, 32'hFFFF0000, ~(14'd1 << 5), IDLE, 6'd7, 6'd0);
    chk("entry5_set", dout_a, 32'hFFFF0000);
    saved = int'(wcount);
    step(1'b0, 32'hAAAAAAAA, ~(14'd1 << 5), ~(14'd1 << 5), 6'd7, 6'd7);
    chk("clear_prio", dout_a, 32'd0);
    chk("clear_count", {24'd0, wcount}, 32'(saved));

    // Multi-load is legal, flagged and sticky; out-of-range reads are zero.
    step(1'b0, 32'h5, 14'b11111111111100, IDLE, 6'd2, 6'd3);
    chk("multi_a", dout_a, 32'h5);
    chk("multi_b", dout_b, 32'h5);
    chk("multi_flag", {31'd0, multi}, 32'd1);
    step(1'b0, 32'h77, IDLE, IDLE, 6'd0, 6'd2);
    chk("addr0", dout_a, 32'd0);
    chk("multi_sticky", {31'd0, multi}, 32'd1);
    step(1'b0, 32'h77, IDLE, IDLE, 6'd40, 6'd1);
    chk("addr40", dout_a, 32'd0);
    chk("addr1", dout_b, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: ld = IDLE;
        1, 2: ld = ~(14'd1 << $urandom_range(0, 13));
        default: ld = 14'($urandom);
      endcase
      cl = ($urandom_range(0, 5) == 0) ? ~(14'd1 << $urandom_range(0, 13)) : IDLE;
      if ($urandom_range(0, 9) == 0) cl = cl & 14'($urandom);
      aa = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'($urandom_range(2, 15));
      ab = ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'($urandom_range(2, 15));
      step(($urandom_range(0, 99) == 0), $urandom, ld, cl, aa, ab);
    end

    // Saturation, then reset mid-sequence.
    step(1'b1, 32'd0, IDLE, IDLE, 6'd0, 6'd0);
    for (int n = 0; n < 300; n++)
      step(1'b0, $urandom, ~(14'd1 << (n % 14)), IDLE, 6'($urandom_range(2, 15)), 6'($urandom));
    chk("sat_255", {24'd0, wcount}, 32'd255);
    step(1'b0, 32'h1, 14'b11111111111110, IDLE, 6'd2, 6'd2);
    chk("sat_hold", {24'd0, wcount}, 32'd255);
    step(1'b1, 32'h1, 14'b11111111111110, IDLE, 6'd2, 6'd2);
    chk("sat_reset", {24'd0, wcount}, 32'd0);
    step(1'b0, 32'h9, 14'b11111111111110, IDLE, 6'd2, 6'd2);
    chk("after_reset_count", {24'd0, wcount}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
